// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the datapath.
// The master side is the controller: it reads the latched instruction fields
// and the live ALU flags and drives every datapath select and enable.
interface multicycle_controller_if;
    logic [19:0] Instr;       // Instr[31:12]: cond, op, funct, Rn, Rd
    logic [3:0]  ALUFlags;    // live {N,Z,C,V}
    logic        PCWrite;
    logic        RegWrite;
    logic        MemWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  ALUControl;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
    );
endinterface

// File: rtl/multicycle_controller.sv
// Control unit for the ARM multicycle processor: main Moore FSM, ALU and
// source decoders, NZCV flag register and conditional-execution gating.
module multicycle_controller #(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic                          clk,
    input  logic                          reset,   // asynchronous, active low
    multicycle_controller_if.master       bus
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    state_t state_reg, state_next;

    // Instruction field views
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unused_rn;

    assign cond      = bus.Instr[19:16];
    assign op        = bus.Instr[15:14];
    assign funct     = bus.Instr[13:8];
    assign rd        = bus.Instr[3:0];
    assign unused_rn = ^bus.Instr[7:4];   // Rn is consumed by the datapath only

    // Moore control terms
    logic       next_pc, branch, reg_w, mem_w, ir_write, adr_src, alu_op;
    logic [1:0] alu_src_a, alu_src_b, result_src;

    // ALU decode terms
    logic [1:0] dp_control;
    logic       dp_arith, dp_cmp, dp_unknown;
    logic [1:0] flag_w;
    logic       no_write;

    // Conditional execution
    logic [3:0] flags_reg;
    logic       cond_ex, cond_ex_reg;
    logic       pcs;

    // State register; reset parks the machine in FETCH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= S_FETCH;
        else        state_reg <= state_next;
    end

    // Next-state logic and per-state Moore controls
    always_comb begin
        state_next = S_FETCH;
        next_pc    = 1'b0;
        branch     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        alu_op     = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        case (state_reg)
            S_FETCH: begin
                state_next = S_DECODE;
                ir_write   = 1'b1;
                next_pc    = 1'b1;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op)
                    2'b01:   state_next = S_MEMADR;
                    2'b00:   state_next = funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   state_next = S_BRANCH;
                    default: state_next = S_FETCH;   // op=11 is a NOP
                endcase
            end
            S_MEMADR: begin
                state_next = funct[0] ? S_MEMRD : S_MEMWR;
                alu_src_b  = 2'b01;
            end
            S_MEMRD: begin
                state_next = S_MEMWB;
                adr_src    = 1'b1;
            end
            S_MEMWB: begin
                state_next = S_FETCH;
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            S_MEMWR: begin
                state_next = S_FETCH;
                adr_src    = 1'b1;
                mem_w      = 1'b1;
            end
            S_EXECR: begin
                state_next = S_ALUWB;
                alu_op     = 1'b1;
            end
            S_EXECI: begin
                state_next = S_ALUWB;
                alu_src_b  = 2'b01;
                alu_op     = 1'b1;
            end
            S_ALUWB: begin
                state_next = S_FETCH;
                reg_w      = 1'b1;
            end
            S_BRANCH: begin
                state_next = S_FETCH;
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Data-processing opcode decode on funct[4:1]
    always_comb begin
        dp_control = 2'b00;
        dp_arith   = 1'b0;
        dp_cmp     = 1'b0;
        dp_unknown = 1'b0;
        case (funct[4:1])
            4'b0100: dp_arith = 1'b1;                                    // ADD
            4'b0010: begin dp_control = 2'b01; dp_arith = 1'b1; end      // SUB
            4'b0000: dp_control = 2'b10;                                 // AND
            4'b1100: dp_control = 2'b11;                                 // ORR
            4'b1010: begin dp_control = 2'b01; dp_arith = 1'b1; dp_cmp = 1'b1; end
            default: dp_unknown = 1'b1;
        endcase
    end

    // NoWrite must still hold in ALUWB (ALUOp=0 there), so it comes straight
    // from the latched funct; it only applies to data-processing instructions
    // so that loads whose funct bits alias an unknown opcode still write back.
    assign no_write   = (op == 2'b00) & (dp_cmp | dp_unknown);
    assign flag_w[1]  = alu_op & (funct[0] | dp_cmp);
    assign flag_w[0]  = flag_w[1] & dp_arith;

    // Condition check against the stored flags
    always_comb begin
        case (cond)
            4'b0000: cond_ex = flags_reg[2];                              // EQ
            4'b0001: cond_ex = ~flags_reg[2];                             // NE
            4'b0010: cond_ex = flags_reg[1];                              // CS
            4'b0011: cond_ex = ~flags_reg[1];                             // CC
            4'b0100: cond_ex = flags_reg[3];                              // MI
            4'b0101: cond_ex = ~flags_reg[3];                             // PL
            4'b0110: cond_ex = flags_reg[0];                              // VS
            4'b0111: cond_ex = ~flags_reg[0];                             // VC
            4'b1000: cond_ex = flags_reg[1] & ~flags_reg[2];              // HI
            4'b1001: cond_ex = ~flags_reg[1] | flags_reg[2];              // LS
            4'b1010: cond_ex = (flags_reg[3] == flags_reg[0]);            // GE
            4'b1011: cond_ex = (flags_reg[3] != flags_reg[0]);            // LT
            4'b1100: cond_ex = ~flags_reg[2] & (flags_reg[3] == flags_reg[0]); // GT
            4'b1101: cond_ex = flags_reg[2] | (flags_reg[3] != flags_reg[0]);  // LE
            4'b1110: cond_ex = 1'b1;                                      // AL
            default: cond_ex = 1'b0;
        endcase
    end

    // Flag register and the registered condition result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_reg   <= FLAGS_RST;
            cond_ex_reg <= 1'b0;
        end else begin
            cond_ex_reg <= cond_ex;
            if (flag_w[1] & cond_ex) flags_reg[3:2] <= bus.ALUFlags[3:2];
            if (flag_w[0] & cond_ex) flags_reg[1:0] <= bus.ALUFlags[1:0];
        end
    end

    // Gated enables are forced low while reset is held, even mid-instruction
    assign pcs            = branch | (reg_w & (rd == 4'd15));
    assign bus.PCWrite    = reset & (next_pc | (pcs & cond_ex_reg));
    assign bus.RegWrite   = reset & reg_w & cond_ex_reg & ~no_write & (rd != 4'd15);
    assign bus.MemWrite   = reset & mem_w & cond_ex_reg;
    assign bus.IRWrite    = reset & ir_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ResultSrc  = result_src;
    assign bus.ImmSrc     = op;
    assign bus.ALUControl = alu_op ? dp_control : 2'b00;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each issued instruction pushes
// its expected per-cycle control vectors; a negedge monitor pops and compares.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_controller_if bus();

    multicycle_controller #(.FLAGS_RST(4'b0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       pcw, regw, memw, irw, adr;
        logic [1:0] regsrc, srca, srcb, res, imm, alu;
    } ctl_t;

    ctl_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] m_flags;       // model {N,Z,C,V}
    logic       checking = 1'b0;
    ctl_t       mon_exp, mon_obs;

    function automatic ctl_t observed();
        ctl_t o;
        o.pcw = bus.PCWrite;  o.regw = bus.RegWrite; o.memw = bus.MemWrite;
        o.irw = bus.IRWrite;  o.adr = bus.AdrSrc;    o.regsrc = bus.RegSrc;
        o.srca = bus.ALUSrcA; o.srcb = bus.ALUSrcB;  o.res = bus.ResultSrc;
        o.imm = bus.ImmSrc;   o.alu = bus.ALUControl;
        return o;
    endfunction

    // ARM condition codes come in pairs: odd code = negation of the even one
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    // Reference model: expected control vector for every cycle of one instruction
    task automatic issue(input logic [19:0] ins, input logic [3:0] af, output int ncyc);
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] rd;
        logic       c, arith, nowr, cmp, set_nz;
        logic [1:0] alu;
        ctl_t       base, e;
        op = ins[15:14]; fn = ins[13:8]; rd = ins[3:0];
        c  = cond_holds(ins[19:16], m_flags);
        base = '0;
        base.regsrc = {op == 2'b01, op == 2'b10};
        base.imm = op;
        e = base; e.pcw = 1; e.irw = 1; e.srca = 2'b01; e.srcb = 2'b10; e.res = 2'b10;
        exp_q.push_back(e);                                   // FETCH
        e = base; e.srca = 2'b01; e.srcb = 2'b10; e.res = 2'b10;
        exp_q.push_back(e);                                   // DECODE
        ncyc = 2;
        case (op)
            2'b01: begin
                e = base; e.srcb = 2'b01; exp_q.push_back(e);
                if (fn[0]) begin
                    e = base; e.adr = 1; exp_q.push_back(e);
                    e = base; e.res = 2'b01; e.regw = c && rd != 15; e.pcw = c && rd == 15;
                    exp_q.push_back(e);
                    ncyc = 5;
                end else begin
                    e = base; e.adr = 1; e.memw = c; exp_q.push_back(e);
                    ncyc = 4;
                end
            end
            2'b00: begin
                arith = 0; nowr = 0; cmp = 0;
                case (fn[4:1])
                    4'b0100: begin alu = 2'b00; arith = 1; end
                    4'b0010: begin alu = 2'b01; arith = 1; end
                    4'b0000: alu = 2'b10;
                    4'b1100: alu = 2'b11;
                    4'b1010: begin alu = 2'b01; arith = 1; nowr = 1; cmp = 1; end
                    default: begin alu = 2'b00; nowr = 1; end
                endcase
                e = base; e.srcb = fn[5] ? 2'b01 : 2'b00; e.alu = alu; exp_q.push_back(e);
                e = base; e.regw = c && !nowr && rd != 15; e.pcw = c && rd == 15;
                exp_q.push_back(e);
                set_nz = fn[0] || cmp;
                if (c && set_nz) m_flags[3:2] = af[3:2];
                if (c && set_nz && arith) m_flags[1:0] = af[1:0];
                ncyc = 4;
            end
            2'b10: begin
                e = base; e.srca = 2'b10; e.srcb = 2'b01; e.res = 2'b10; e.pcw = c;
                exp_q.push_back(e);
                ncyc = 3;
            end
            default: ncyc = 2;
        endcase
    endtask

    // Issue one instruction and hold it for its full latency
    task automatic run_instr(input logic [19:0] ins, input logic [3:0] af);
        int n;
        issue(ins, af, n);
        bus.Instr = ins;
        bus.ALUFlags = af;
        $display("instr=%h aluflags=%b cycles=%0d model_flags=%b", ins, af, n, m_flags);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: enables low during reset, otherwise compare against scoreboard
    always @(negedge clk) begin
        if (checking) begin
            if (!reset) begin
                checks++;
                if ({bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.IRWrite} != 4'b0000) begin
                    errors++;
                    $display("FAIL reset_enables got=%b want=0000",
                             {bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.IRWrite});
                end
            end else if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_obs = observed();
                checks++;
                if (mon_obs !== mon_exp) begin
                    errors++;
                    $display("FAIL ctl_vector instr=%h got=%h want=%h", bus.Instr, mon_obs, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    logic [19:0] r_ins;
    logic [3:0]  r_af;
    int          n_mid;

    initial begin
        reset = 1'b1;
        bus.Instr = '0;
        bus.ALUFlags = '0;
        m_flags = 4'b0000;
        #1 reset = 1'b0;
        checking = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Directed sequence
        run_instr(20'hE0821, 4'b0000);   // ADD R1,R2,R3
        run_instr(20'hE5921, 4'b0000);   // LDR
        run_instr(20'hE5821, 4'b0000);   // STR
        run_instr(20'hE2500, 4'b0100);   // SUBS -> Z=1
        run_instr(20'h1AFFF, 4'b0000);   // BNE not taken
        run_instr(20'h0AFFF, 4'b0000);   // BEQ taken
        run_instr(20'hE08FF, 4'b0000);   // ADD PC,PC,R3
        run_instr(20'hE1500, 4'b1001);   // CMP
        run_instr(20'hF0821, 4'b0000);   // cond 1111 never executes
        run_instr(20'hE2500, 4'b0110);   // SUBS -> Z=1 again before reset test

        // Reset pulsed in the middle of MEMRD
        issue(20'hE5921, 4'b0000, n_mid);
        bus.Instr = 20'hE5921;
        $display("instr=%h reset pulsed in MEMRD", bus.Instr);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        m_flags = 4'b0000;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        run_instr(20'h0AFFF, 4'b0000);   // BEQ must not be taken: Z cleared
        run_instr(20'h1AFFF, 4'b0000);   // BNE taken

        // Randomized sequence
        for (int k = 0; k < 160; k++) begin
            r_ins = 20'($urandom);
            r_af  = 4'($urandom);
            if ($urandom_range(0, 3) == 0) r_ins[19:16] = 4'hE;
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 4))
                    0: r_ins[12:9] = 4'b0100;
                    1: r_ins[12:9] = 4'b0010;
                    2: r_ins[12:9] = 4'b0000;
                    3: r_ins[12:9] = 4'b1100;
                    default: r_ins[12:9] = 4'b1010;
                endcase
            end
            if ($urandom_range(0, 3) == 0) r_ins[3:0] = 4'hF;
            run_instr(r_ins, r_af);
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the ARM multicycle processor; it sits directly upstream of the multicycle datapath.
- Consumes the latched instruction fields and the live ALU flags from the datapath.
- Produces every datapath select and write enable, plus MemWrite for data memory.
- Contains the main Moore FSM, the ALU/immediate/register-source decoders, the NZCV flag register and the conditional-execution logic.

Parameters:
FLAGS_RST, 4'b0000, reset value of the stored {N,Z,C,V} register

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous active-low reset
Instr  input  20  Instr[31:12] from the instruction register: cond[31:28], op[27:26], funct[25:20], Rd[15:12]
ALUFlags  input  4  live ALU {N,Z,C,V}
PCWrite  output  1  PC register enable
RegWrite  output  1  register file write enable
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction register enable
AdrSrc  output  1  0=PC, 1=Result as memory address
RegSrc  output  2  [0]: RA1=R15; [1]: RA2=Rd
ALUSrcA  output  2  00=A, 01=PC, 10=ALUOut
ALUSrcB  output  2  00=WriteData, 01=ExtImm, 10=constant 4
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
ImmSrc  output  2  equals op
ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR

Behaviour:
- Reset low:
  - FSM goes to FETCH; flag register goes to FLAGS_RST; CondExR (registered CondEx) goes to 0.
  - PCWrite, RegWrite, MemWrite and IRWrite are forced 0 while reset is low, including a reset asserted mid-instruction.
- FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- Transitions:
  - FETCH->DECODE.
  - DECODE: op=01->MEMADR; op=00 & funct[5]=0->EXECR; op=00 & funct[5]=1->EXECI; op=10->BRANCH; op=11->FETCH (treated as NOP).
  - MEMADR: funct[0]=1->MEMRD, else MEMWR.
  - MEMRD->MEMWB->FETCH.
  - MEMWR->FETCH.
  - EXECR/EXECI->ALUWB->FETCH.
  - BRANCH->FETCH.
- Moore controls per state; unlisted signals are 0, ALUOp=0 means ADD:
  - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10 (computes PC+8).
  - MEMADR: ALUSrcA=00, ALUSrcB=01.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode, active when ALUOp=1, keyed on funct[4:1]:
  - 0100 ADD->00; 0010 SUB->01; 0000 AND->10; 1100 ORR->11; 1010 CMP->01 with NoWrite=1.
  - Any other value->00 with NoWrite=1.
  - FlagW[1] (N,Z) = funct[0] or CMP.
  - FlagW[0] (C,V) = FlagW[1] and the operation is ADD/SUB/CMP.
  - ALUOp=0: ALUControl=00, FlagW=00.
- Combinational decodes: ImmSrc=op; RegSrc[0]=(op==10); RegSrc[1]=(op==01).
- Conditional logic:
  - CondEx is a combinational function of cond and the stored flags: EQ, NE, CS, CC, MI, PL, VS, VC, HI=C&~Z, LS=~C|Z, GE=N==V, LT, GT=~Z&(N==V), LE, AL=1; cond 1111 gives 0.
  - CondExR <= CondEx every cycle.
  - Flag register: {N,Z} loads ALUFlags[3:2] when FlagW[1]&CondEx; {C,V} loads ALUFlags[1:0] when FlagW[0]&CondEx. Flags become visible the cycle after EXEC.
- Gated outputs:
  - PCS = Branch | (RegW & Rd==15).
  - PCWrite = NextPC | (PCS & CondExR).
  - RegWrite = RegW & CondExR & ~NoWrite & (Rd!=15).
  - MemWrite = MemW & CondExR.
- Latency: data-processing 4 cycles; LDR 5; STR 4; B 3; op=11 2.

Test Plan:
- Reset low for 2 cycles, then release → state FETCH; all enables 0 during reset; first cycle after release IRWrite=1, PCWrite=1, ALUSrcB=10.
- Instr=E0821 (ADD R1,R2,R3), flags 0 → FETCH, DECODE, EXECR, ALUWB; EXECR gives ALUControl=00, ALUSrcB=00; ALUWB gives RegWrite=1; flags unchanged.
- Instr=E5921 (LDR) → MEMADR, MEMRD, MEMWB with ResultSrc=01, RegWrite=1 (5 cycles). Instr=E5821 (STR) → MEMWR with MemWrite=1, AdrSrc=1 (4 cycles).
- Instr=E2500 (SUBS), ALUFlags=0100 in EXECI → Z=1 stored. Then Instr=1AFFF (BNE) → BRANCH with PCWrite=0. Then Instr=0AFFF (BEQ) → BRANCH with PCWrite=1.
- Instr=E08FF (ADD PC,PC,R3) → ALUWB gives PCWrite=1, RegWrite=0, ResultSrc=00. Instr=E1500 (CMP) → RegWrite=0 in ALUWB, flags updated.
- Reset pulsed low during MEMRD → immediate return to FETCH; MemWrite/RegWrite stay 0; stored flags return to 0000.
